// File: rtl/wb_stage_mlane.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_mlane
// Brief    : Multi-lane writeback stage. Retires one lane of a MEM bundle
//            per cycle in program order and drives the debug trace port.
//            Optional macro WB_ZERO_SKIP_EN skips non-writing lanes.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_mlane #(
    parameter int LANES   = 2,
    parameter int LANE_WD = 71,
    parameter int IDX_W   = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    output logic                       wb_allowin,
    input  logic                       mem_to_wb_valid,
    input  logic [LANES*LANE_WD-1:0]   mem_to_wb_bus,
    output logic [LANES*39-1:0]        wb_to_id_bus,
    output logic [31:0]                debug_wb_pc,
    output logic [3:0]                 debug_wb_rf_wen,
    output logic [4:0]                 debug_wb_rf_wnum,
    output logic [31:0]                debug_wb_rf_wdata
);

    logic                     r_wb_valid;
    logic [LANES*LANE_WD-1:0] r_wb_data;
    logic [IDX_W-1:0]         r_ptr;

    logic [LANES-1:0] w_wr;
    logic [LANES-1:0] w_we;
    logic [4:0]       w_waddr [LANES];
    logic [31:0]      w_wdata [LANES];
    logic [31:0]      w_pc    [LANES];
    logic [IDX_W-1:0] w_first;
    logic [IDX_W-1:0] w_next;
    logic             w_last;
    logic             w_ready_go;
    logic             w_accept;
`ifdef WB_ZERO_SKIP_EN
    logic [LANES-1:0] w_in_wr;
`endif

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            logic w_pend;
            assign w_wr[g]    = r_wb_data[g*LANE_WD + 70] & r_wb_data[g*LANE_WD + 69];
            assign w_waddr[g] = r_wb_data[g*LANE_WD + 64 +: 5];
            assign w_wdata[g] = r_wb_data[g*LANE_WD + 32 +: 32];
            assign w_pc[g]    = r_wb_data[g*LANE_WD +: 32];
            // Pending covers the lane being written now and every younger writer.
            assign w_pend     = r_wb_valid & w_wr[g] & (r_ptr <= IDX_W'(g));
            assign w_we[g]    = r_wb_valid & w_wr[g] & (r_ptr == IDX_W'(g));
            assign wb_to_id_bus[g*39 +: 39] =
                {w_pend, w_we[g], (w_pend ? w_waddr[g] : 5'd0), w_wdata[g]};
`ifdef WB_ZERO_SKIP_EN
            assign w_in_wr[g] = mem_to_wb_bus[g*LANE_WD + 70] & mem_to_wb_bus[g*LANE_WD + 69];
`endif
        end
    endgenerate

    always_comb begin
        w_first = '0;
        w_next  = r_ptr;
        w_last  = 1'b0;
`ifdef WB_ZERO_SKIP_EN
        // Descending scans leave the lowest qualifying lane selected.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_in_wr[i]) begin
                w_first = IDX_W'(i);
            end
        end
        w_last = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_wr[i] && (IDX_W'(i) > r_ptr)) begin
                w_next = IDX_W'(i);
                w_last = 1'b0;
            end
        end
`else
        w_last = (r_ptr == IDX_W'(LANES - 1));
        w_next = r_ptr + IDX_W'(1);
`endif
    end

    assign w_ready_go = r_wb_valid & w_last;
    assign wb_allowin = ~r_wb_valid | w_ready_go;
    assign w_accept   = wb_allowin & mem_to_wb_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wb_valid <= 1'b0;
            r_ptr      <= '0;
            r_wb_data  <= '0;
        end else if (w_accept) begin
            r_wb_valid <= 1'b1;
            r_ptr      <= w_first;
            r_wb_data  <= mem_to_wb_bus;
        end else if (r_wb_valid) begin
            if (w_last) begin
                r_wb_valid <= 1'b0;
            end else begin
                r_ptr <= w_next;
            end
        end
    end

    always_comb begin
        debug_wb_pc       = '0;
        debug_wb_rf_wen   = '0;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_ptr == IDX_W'(i)) begin
                debug_wb_pc       = w_pc[i];
                debug_wb_rf_wen   = {4{w_we[i]}};
                debug_wb_rf_wnum  = w_waddr[i];
                debug_wb_rf_wdata = w_wdata[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_mlane.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage_mlane
// Brief    : Directed self-checking bench for wb_stage_mlane (LANES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage_mlane;

    localparam int LANES   = 2;
    localparam int LANE_WD = 71;
    localparam int IDX_W   = 2;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic                     wb_allowin;
    logic                     mem_to_wb_valid;
    logic [LANES*LANE_WD-1:0] mem_to_wb_bus;
    logic [LANES*39-1:0]      wb_to_id_bus;
    logic [31:0]              debug_wb_pc;
    logic [3:0]               debug_wb_rf_wen;
    logic [4:0]               debug_wb_rf_wnum;
    logic [31:0]              debug_wb_rf_wdata;

    int n_cmp  = 0;
    int n_fail = 0;

    int          n_wr   = 0;
    logic [31:0] rf7    = '0;
    bit          seen21 = 1'b0;

    wb_stage_mlane #(.LANES(LANES), .LANE_WD(LANE_WD), .IDX_W(IDX_W)) u_dut (
        .clk              (clk),
        .resetn           (resetn),
        .wb_allowin       (wb_allowin),
        .mem_to_wb_valid  (mem_to_wb_valid),
        .mem_to_wb_bus    (mem_to_wb_bus),
        .wb_to_id_bus     (wb_to_id_bus),
        .debug_wb_pc      (debug_wb_pc),
        .debug_wb_rf_wen  (debug_wb_rf_wen),
        .debug_wb_rf_wnum (debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    always #5 clk = ~clk;

    // Register-file view reconstructed from the trace port.
    always @(posedge clk) begin
        if (debug_wb_rf_wen == 4'hf) begin
            n_wr = n_wr + 1;
            if (debug_wb_rf_wnum == 5'd7)  rf7 = debug_wb_rf_wdata;
            if (debug_wb_rf_wnum == 5'd21) seen21 = 1'b1;
        end
    end

    function automatic logic [LANE_WD-1:0] lane(input logic v, input logic rw,
            input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        return {v, rw, a, d, pc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] pend();
        return {wb_to_id_bus[77], wb_to_id_bus[38]};
    endfunction

    initial begin
        resetn          = 1'b0;
        mem_to_wb_valid = 1'b1;
        mem_to_wb_bus   = {lane(1, 1, 5'd9, 32'h99, 32'h1c000100),
                           lane(1, 1, 5'd8, 32'h88, 32'h1c0000fc)};
        repeat (3) tick();
        chk("rst_allowin", 64'(wb_allowin), 64'd1);
        chk("rst_idbus",   64'(wb_to_id_bus[63:0]), 64'd0);
        chk("rst_idbus_hi", 64'(wb_to_id_bus[77:64]), 64'd0);
        chk("rst_wen",     64'(debug_wb_rf_wen), 64'd0);
        chk("rst_pc",      64'(debug_wb_pc), 64'd0);

        // Basic two-lane bundle
        resetn        = 1'b1;
        mem_to_wb_bus = {lane(1, 1, 5'd5, 32'h22, 32'h1c000004),
                         lane(1, 1, 5'd4, 32'h11, 32'h1c000000)};
        tick();
        mem_to_wb_valid = 1'b0;
        chk("b1c1_wen",     64'(debug_wb_rf_wen), 64'hf);
        chk("b1c1_wnum",    64'(debug_wb_rf_wnum), 64'd4);
        chk("b1c1_wdata",   64'(debug_wb_rf_wdata), 64'h11);
        chk("b1c1_pc",      64'(debug_wb_pc), 64'h1c000000);
        chk("b1c1_pend",    64'(pend()), 64'b11);
        chk("b1c1_allowin", 64'(wb_allowin), 64'd0);
        tick();
        chk("b1c2_wnum",    64'(debug_wb_rf_wnum), 64'd5);
        chk("b1c2_pc",      64'(debug_wb_pc), 64'h1c000004);
        chk("b1c2_pend",    64'(pend()), 64'b10);
        chk("b1c2_allowin", 64'(wb_allowin), 64'd1);
        chk("b1c2_l0we",    64'(wb_to_id_bus[37]), 64'd0);
        chk("b1c2_l0addr",  64'(wb_to_id_bus[36:32]), 64'd0);
        tick();
        chk("b1_idle_wen",  64'(debug_wb_rf_wen), 64'd0);
        chk("b1_idle_pend", 64'(pend()), 64'b00);

        // Same destination in both lanes
        mem_to_wb_valid = 1'b1;
        mem_to_wb_bus   = {lane(1, 1, 5'd7, 32'hB, 32'h1c000014),
                           lane(1, 1, 5'd7, 32'hA, 32'h1c000010)};
        tick();
        mem_to_wb_valid = 1'b0;
        chk("sd_c1_wdata", 64'(debug_wb_rf_wdata), 64'hA);
        chk("sd_c1_pend",  64'(pend()), 64'b11);
        tick();
        chk("sd_c2_wnum",  64'(debug_wb_rf_wnum), 64'd7);
        chk("sd_c2_wdata", 64'(debug_wb_rf_wdata), 64'hB);
        tick();
        chk("sd_rf7",      64'(rf7), 64'hB);

        // Lane 0 does not write
        mem_to_wb_valid = 1'b1;
        mem_to_wb_bus   = {lane(1, 1, 5'd3, 32'h5, 32'h1c000024),
                           lane(1, 0, 5'd9, 32'h99, 32'h1c000020)};
        tick();
        mem_to_wb_valid = 1'b0;
`ifdef WB_ZERO_SKIP_EN
        chk("nw_c1_wen",     64'(debug_wb_rf_wen), 64'hf);
        chk("nw_c1_wnum",    64'(debug_wb_rf_wnum), 64'd3);
        chk("nw_c1_allowin", 64'(wb_allowin), 64'd1);
`else
        chk("nw_c1_wen",     64'(debug_wb_rf_wen), 64'h0);
        chk("nw_c1_pc",      64'(debug_wb_pc), 64'h1c000020);
        chk("nw_c1_pend",    64'(pend()), 64'b10);
        tick();
        chk("nw_c2_wen",     64'(debug_wb_rf_wen), 64'hf);
        chk("nw_c2_wnum",    64'(debug_wb_rf_wnum), 64'd3);
        chk("nw_c2_wdata",   64'(debug_wb_rf_wdata), 64'h5);
`endif
        tick();
        chk("nw_idle_wen", 64'(debug_wb_rf_wen), 64'h0);

        // Four back-to-back bundles, all lanes writing
        begin
            int base_wr;
            base_wr         = n_wr;
            mem_to_wb_valid = 1'b1;
            mem_to_wb_bus   = {lane(1, 1, 5'd11, 32'd2, 32'h1c000204),
                               lane(1, 1, 5'd10, 32'd1, 32'h1c000200)};
            for (int c = 0; c < 8; c++) begin
                tick();
                chk("b2b_wen",   64'(debug_wb_rf_wen), 64'hf);
                chk("b2b_wnum",  64'(debug_wb_rf_wnum), 64'(10 + c));
                chk("b2b_wdata", 64'(debug_wb_rf_wdata), 64'(c + 1));
                if (c % 2 == 0) begin
                    if (c < 6) begin
                        mem_to_wb_bus = {lane(1, 1, 5'(12 + c + 1), 32'(c + 4), 32'h1c000300),
                                         lane(1, 1, 5'(12 + c),     32'(c + 3), 32'h1c0002fc)};
                    end else begin
                        mem_to_wb_valid = 1'b0;
                    end
                end
            end
            tick();
            chk("b2b_count",    64'(n_wr - base_wr), 64'd8);
            chk("b2b_idle_wen", 64'(debug_wb_rf_wen), 64'h0);
        end

        // Reset in the first cycle of a bundle
        mem_to_wb_valid = 1'b1;
        mem_to_wb_bus   = {lane(1, 1, 5'd21, 32'h88, 32'h1c000404),
                           lane(1, 1, 5'd20, 32'h77, 32'h1c000400)};
        tick();
        mem_to_wb_valid = 1'b0;
        chk("mr_c1_wnum", 64'(debug_wb_rf_wnum), 64'd20);
        resetn = 1'b0;
        tick();
        chk("mr_wen",     64'(debug_wb_rf_wen), 64'h0);
        chk("mr_pend",    64'(pend()), 64'b00);
        chk("mr_allowin", 64'(wb_allowin), 64'd1);
        chk("mr_pc",      64'(debug_wb_pc), 64'd0);
        resetn = 1'b1;
        repeat (3) tick();
        chk("mr_no_r21",  64'(seen21), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
